riscv_sim_monitor: RTL and testbench

- Synthesizable run-control and result monitor for the pipelined RV32I core, replacing fixed-length open-loop simulation.
- Generates the core's active-low reset and counts cycles and decoded instructions.
- Snoops memory-stage stores to detect a tohost pass/fail write and console character writes.
- Flags a timeout if the program never terminates. Sits beside riscv_top; the bench only drives i_clk/i_rst and reads the result outputs.

---
 rtl/riscv_configs_pkg.sv | 41 ++++
 rtl/riscv_sat_counter.sv | 23 ++
 rtl/riscv_sim_monitor.sv | 135 +++++++++++++
 tb/tb_riscv_sim_monitor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_configs_pkg.sv
// Shared configuration for the RV32I simulation monitor: widths, magic
// addresses, the bubble encoding and run-control FSM state encodings.
package riscv_configs;

  localparam int unsigned CFG_XLEN         = 32;
  localparam logic [31:0] CFG_NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] CFG_TOHOST_ADDR  = 32'h0000_0FF0;
  localparam logic [31:0] CFG_CONSOLE_ADDR = 32'h0000_0FF4;

  localparam logic [2:0] ST_RESET   = 3'd0;
  localparam logic [2:0] ST_HOLD    = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_PASS    = 3'd3;
  localparam logic [2:0] ST_FAIL    = 3'd4;
  localparam logic [2:0] ST_TIMEOUT = 3'd5;

  typedef enum logic [2:0] {
    S_RESET   = ST_RESET,
    S_HOLD    = ST_HOLD,
    S_RUN     = ST_RUN,
    S_PASS    = ST_PASS,
    S_FAIL    = ST_FAIL,
    S_TIMEOUT = ST_TIMEOUT
  } mon_state_t;

  // Byte carried by the lowest enabled lane of a 32-bit store.
  function automatic logic [7:0] lowest_lane(input logic [3:0]  byte_sel,
                                             input logic [31:0] data);
    logic [7:0] lane;
    lane = 8'h00;
    priority casez (byte_sel)
      4'b???1: lane = data[7:0];
      4'b??10: lane = data[15:8];
      4'b?100: lane = data[23:16];
      4'b1000: lane = data[31:24];
      default: lane = 8'h00;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/riscv_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module riscv_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  // Clear has priority; increment only while below the saturation value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_en && (o_count != {W{1'b1}})) begin
      o_count <= o_count + W'(1);
    end
  end

endmodule

// File: rtl/riscv_sim_monitor.sv
// Run-control and result monitor for the RV32I core: sequences the core
// reset, counts cycles/instructions, and decodes tohost/console stores.
module riscv_sim_monitor
  import riscv_configs::*;
#(
  parameter int unsigned     XLEN         = CFG_XLEN,
  parameter int unsigned     RST_CYCLES   = 4,
  parameter int unsigned     MAX_CYCLES   = 200,
  parameter int unsigned     CNT_W        = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(CFG_TOHOST_ADDR),
  parameter logic [XLEN-1:0] CONSOLE_ADDR = XLEN'(CFG_CONSOLE_ADDR),
  parameter logic [XLEN-1:0] NOP_INSTR    = XLEN'(CFG_NOP_INSTR)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [XLEN-1:0]   i_pc_d,
  input  logic [XLEN-1:0]   i_instr_d,
  input  logic [XLEN-1:0]   i_alu_result_m,
  input  logic              i_mem_write_m,
  input  logic [3:0]        i_byte_sel_m,
  input  logic [XLEN-1:0]   i_write_data_m,
  output logic              o_core_rstn,
  output logic              o_running,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [XLEN-2:0]   o_fail_code,
  output logic [XLEN-1:0]   o_end_pc,
  output logic [CNT_W-1:0]  o_cycle_cnt,
  output logic [CNT_W-1:0]  o_instr_cnt,
  output logic              o_putc_valid,
  output logic [7:0]        o_putc_data
);

  localparam int unsigned HOLD_W = 8;

  mon_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              tohost_hit;
  logic              console_hit;
  logic              budget_hit;
  logic              in_run;
  logic              instr_valid;
  logic              unused_addr_bits;

  // Word-address store decode; the low address bits never select a mailbox.
  assign tohost_hit  = i_mem_write_m &&
                       (i_alu_result_m[XLEN-1:2] == TOHOST_ADDR[XLEN-1:2]) &&
                       (i_byte_sel_m == 4'b1111);
  assign console_hit = i_mem_write_m &&
                       (i_alu_result_m[XLEN-1:2] == CONSOLE_ADDR[XLEN-1:2]) &&
                       (i_byte_sel_m != 4'b0000);
  assign budget_hit  = (o_cycle_cnt == CNT_W'(MAX_CYCLES - 1));
  assign in_run      = (state == S_RUN);
  assign instr_valid = (i_instr_d != NOP_INSTR) && (i_instr_d != '0);
  assign unused_addr_bits = ^i_alu_result_m[1:0];

  riscv_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (state == S_RESET),
    .i_en    (in_run),
    .o_count (o_cycle_cnt)
  );

  riscv_sat_counter #(.W(CNT_W)) u_instr_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (state == S_RESET),
    .i_en    (in_run && instr_valid),
    .o_count (o_instr_cnt)
  );

  // Run-control FSM with all monitor outputs registered alongside the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_RESET;
      hold_cnt     <= '0;
      o_core_rstn  <= 1'b0;
      o_running    <= 1'b0;
      o_done       <= 1'b0;
      o_pass       <= 1'b0;
      o_timeout    <= 1'b0;
      o_fail_code  <= '0;
      o_end_pc     <= '0;
      o_putc_valid <= 1'b0;
      o_putc_data  <= 8'h00;
    end else begin
      o_putc_valid <= 1'b0;
      case (state)
        S_RESET: begin
          state    <= S_HOLD;
          hold_cnt <= '0;
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
            state       <= S_RUN;
            o_core_rstn <= 1'b1;
            o_running   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          if (console_hit) begin
            o_putc_valid <= 1'b1;
            o_putc_data  <= lowest_lane(i_byte_sel_m, i_write_data_m[31:0]);
          end
          if (tohost_hit) begin
            o_running <= 1'b0;
            o_done    <= 1'b1;
            o_end_pc  <= i_pc_d;
            if (i_write_data_m == XLEN'(1)) begin
              state  <= S_PASS;
              o_pass <= 1'b1;
            end else begin
              state       <= S_FAIL;
              o_fail_code <= i_write_data_m[XLEN-1:1];
            end
          end else if (budget_hit) begin
            state     <= S_TIMEOUT;
            o_running <= 1'b0;
            o_done    <= 1'b1;
            o_timeout <= 1'b1;
            o_end_pc  <= i_pc_d;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_sim_monitor.sv
// Scoreboard bench for riscv_sim_monitor: a cycle-level program model pushes
// expected console bytes and terminal results; a negedge monitor pops them.
module tb_riscv_sim_monitor;

  localparam int unsigned MAX_CYC = 200;
  localparam logic [31:0] TOHOST  = 32'h0000_0FF0;
  localparam logic [31:0] CONSOLE = 32'h0000_0FF4;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        i_clk, i_rst;
  logic [31:0] i_pc_d, i_instr_d, i_alu_result_m, i_write_data_m;
  logic        i_mem_write_m;
  logic [3:0]  i_byte_sel_m;
  logic        o_core_rstn, o_running, o_done, o_pass, o_timeout, o_putc_valid;
  logic [30:0] o_fail_code;
  logic [31:0] o_end_pc, o_cycle_cnt, o_instr_cnt;
  logic [7:0]  o_putc_data;

  typedef struct {
    bit          pass;
    bit          timeout;
    logic [30:0] fail_code;
    logic [31:0] end_pc;
    logic [31:0] cycles;
    logic [31:0] instrs;
  } res_t;

  res_t       res_q[$];
  logic [7:0] putc_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         done_seen = 0;

  riscv_sim_monitor #(.RST_CYCLES(4), .MAX_CYCLES(MAX_CYC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pc_d(i_pc_d), .i_instr_d(i_instr_d),
    .i_alu_result_m(i_alu_result_m), .i_mem_write_m(i_mem_write_m),
    .i_byte_sel_m(i_byte_sel_m), .i_write_data_m(i_write_data_m),
    .o_core_rstn(o_core_rstn), .o_running(o_running), .o_done(o_done),
    .o_pass(o_pass), .o_timeout(o_timeout), .o_fail_code(o_fail_code),
    .o_end_pc(o_end_pc), .o_cycle_cnt(o_cycle_cnt), .o_instr_cnt(o_instr_cnt),
    .o_putc_valid(o_putc_valid), .o_putc_data(o_putc_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] low_lane(input logic [3:0] bs, input logic [31:0] d);
    logic [7:0] c;
    bit got;
    c = 8'h00;
    got = 0;
    for (int l = 0; l < 4; l++) begin
      if (bs[l] && !got) begin
        c = d[8*l +: 8];
        got = 1;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] other_addr();
    logic [31:0] a;
    a = $urandom;
    if (a[31:2] == TOHOST[31:2] || a[31:2] == CONSOLE[31:2]) a = a ^ 32'h0001_0000;
    return a;
  endfunction

  function automatic logic [31:0] rand_instr();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return NOP;
    if (r == 1) return 32'h0;
    return $urandom;
  endfunction

  task automatic drive_idle();
    i_mem_write_m  = 1'b0;
    i_byte_sel_m   = 4'h0;
    i_alu_result_m = $urandom;
    i_write_data_m = $urandom;
  endtask

  // Console bytes and terminal results as seen by the monitor.
  always @(negedge i_clk) begin
    logic [7:0] exp_c;
    res_t       exp_r;
    if (!i_rst) begin
      if (o_putc_valid) begin
        if (putc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL putc_unexpected actual=0x%0h expected=no_pulse", o_putc_data);
        end else begin
          exp_c = putc_q.pop_front();
          chk("putc_data", 64'(o_putc_data), 64'(exp_c));
        end
      end
      if (o_done && !done_seen) begin
        done_seen = 1;
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected actual=1 expected=0");
        end else begin
          exp_r = res_q.pop_front();
          chk("pass",      64'(o_pass),      64'(exp_r.pass));
          chk("timeout",   64'(o_timeout),   64'(exp_r.timeout));
          chk("fail_code", 64'(o_fail_code), 64'(exp_r.fail_code));
          chk("end_pc",    64'(o_end_pc),    64'(exp_r.end_pc));
          chk("cycle_cnt", 64'(o_cycle_cnt), 64'(exp_r.cycles));
          chk("instr_cnt", 64'(o_instr_cnt), 64'(exp_r.instrs));
          chk("running_off", 64'(o_running), 64'(0));
        end
      end
    end
  end

  // Hold reset, verify cleared outputs, then release and time the core reset.
  task automatic reset_seq();
    i_rst = 1'b1;
    drive_idle();
    i_instr_d = 32'h0000_0033;
    i_pc_d    = 32'h0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_flags", 64'({o_core_rstn, o_running, o_done, o_pass, o_timeout,
                          o_putc_valid, o_putc_data}), 64'(0));
    chk("rst_counts", {o_cycle_cnt, o_instr_cnt}, 64'(0));
    chk("rst_code_pc", 64'({o_fail_code, o_end_pc}), 64'(0));
    res_q.delete();
    putc_q.delete();
    done_seen = 0;
    i_rst = 1'b0;
    i_mem_write_m  = 1'b1;
    i_alu_result_m = TOHOST;
    i_byte_sel_m   = 4'hF;
    i_write_data_m = 32'h1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge i_clk);
      #1;
      chk("core_rstn_seq", 64'(o_core_rstn), 64'(i == 5));
      chk("running_seq", 64'({o_running, o_done}), (i == 5) ? 64'h2 : 64'h0);
      if (i == 2) begin
        i_alu_result_m = CONSOLE;
        i_byte_sel_m   = 4'h1;
        i_write_data_m = 32'h5A;
      end
    end
    chk("cycle_at_run", 64'(o_cycle_cnt), 64'(0));
  endtask

  // One program run: term_k<0 means no tohost write; abort_k>=0 resets mid-run.
  task automatic run_prog(input int term_k, input logic [31:0] term_data,
                          input bit directed, input int abort_k);
    res_t        exp;
    int          n_instr;
    bit          fin;
    bit          term;
    int unsigned sel;
    logic [31:0] p;
    n_instr = 0;
    fin = 0;
    exp = '{default: '0};
    reset_seq();
    for (int k = 0; k < int'(MAX_CYC) && !fin; k++) begin
      if (k == abort_k) begin
        chk("cycle_before_abort", 64'(o_cycle_cnt), 64'(k));
        i_rst = 1'b1;
        #1;
        chk("abort_flags", 64'({o_core_rstn, o_running, o_done, o_pass, o_timeout}), 64'(0));
        chk("abort_counts", {o_cycle_cnt, o_instr_cnt}, 64'(0));
        res_q.delete();
        putc_q.delete();
        return;
      end
      p = $urandom;
      i_pc_d = p & 32'hFFFF_FFFC;
      if (directed) i_instr_d = (k < 13) ? ((k % 4 == 3) ? NOP : 32'h00A0_0093 + 32'(k)) : 32'h0;
      else          i_instr_d = rand_instr();
      if (i_instr_d != NOP && i_instr_d != 32'h0) n_instr++;
      drive_idle();
      if (k == term_k) begin
        i_mem_write_m  = 1'b1;
        i_alu_result_m = TOHOST | ($urandom % 4);
        i_byte_sel_m   = 4'hF;
        i_write_data_m = term_data;
      end else if (directed) begin
        if (k == 5) begin
          i_mem_write_m = 1'b1; i_alu_result_m = CONSOLE; i_byte_sel_m = 4'h1;
          i_write_data_m = 32'h0000_0041;
          putc_q.push_back(8'h41);
        end else if (k == 20) begin
          i_mem_write_m = 1'b1; i_alu_result_m = TOHOST; i_byte_sel_m = 4'h1;
          i_write_data_m = 32'h1;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        sel = $urandom_range(0, 2);
        i_mem_write_m = 1'b1;
        if (sel == 0) begin
          i_alu_result_m = CONSOLE | ($urandom % 4);
          i_byte_sel_m   = 4'($urandom_range(1, 15));
          putc_q.push_back(low_lane(i_byte_sel_m, i_write_data_m));
        end else if (sel == 1) begin
          i_alu_result_m = TOHOST;
          i_byte_sel_m   = 4'($urandom_range(1, 14));
          i_write_data_m = 32'h1;
        end else begin
          i_alu_result_m = other_addr();
          i_byte_sel_m   = 4'hF;
        end
      end
      term = (k == term_k) || (k == int'(MAX_CYC) - 1);
      if (term) begin
        exp.pass      = (k == term_k) && (term_data == 32'h1);
        exp.timeout   = (k != term_k);
        exp.fail_code = (k == term_k && term_data != 32'h1) ? term_data[31:1] : 31'h0;
        exp.end_pc    = i_pc_d;
        exp.cycles    = 32'(k + 1);
        exp.instrs    = 32'(n_instr);
        res_q.push_back(exp);
      end
      @(posedge i_clk);
      #1;
      chk(term ? "done_timing" : "no_early_done", 64'(o_done), 64'(term));
      fin = term;
    end
    for (int j = 0; j < 6; j++) begin
      i_instr_d = rand_instr();
      drive_idle();
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        i_mem_write_m = 1'b1; i_alu_result_m = TOHOST; i_byte_sel_m = 4'hF;
      end else if (sel == 1) begin
        i_mem_write_m = 1'b1; i_alu_result_m = CONSOLE; i_byte_sel_m = 4'hF;
      end
      @(posedge i_clk);
      #1;
    end
    drive_idle();
    @(negedge i_clk);
    chk("frozen_cycles", 64'(o_cycle_cnt), 64'(exp.cycles));
    chk("frozen_instrs", 64'(o_instr_cnt), 64'(exp.instrs));
    chk("absorb_flags", 64'({o_done, o_core_rstn, o_running, o_pass, o_timeout}),
        64'({3'b110, exp.pass, exp.timeout}));
    chk("putc_pending", 64'(putc_q.size()), 64'(0));
    chk("result_pending", 64'(res_q.size()), 64'(0));
  endtask

  initial begin
    i_rst = 1'b1;
    i_instr_d = 32'h0;
    i_pc_d = 32'h0;
    drive_idle();
    run_prog(50, 32'h1, 1'b1, -1);
    run_prog(30, 32'h7, 1'b0, -1);
    run_prog(-1, 32'h0, 1'b0, -1);
    run_prog(199, 32'h1, 1'b0, -1);
    run_prog(-1, 32'h0, 1'b0, 40);
    run_prog(int'($urandom_range(10, 150)), 32'h0, 1'b0, -1);
    repeat (3) run_prog(int'($urandom_range(5, 190)), $urandom, 1'b0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
